priority_arbiter_8: RTL and testbench

PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

---
 rtl/priority_arbiter_8_pkg.sv | 23 ++
 rtl/priority_arbiter_8_if.sv | 22 ++
 rtl/priority_arbiter_8_prio_enc.sv | 20 ++
 rtl/priority_arbiter_8.sv | 107 ++++++++++
 tb/tb_priority_arbiter_8.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/priority_arbiter_8_pkg.sv
// Shared constants for the 8-way arbiter: FSM and mode encodings, requester
// count, and the rotate helper used for round-robin search.
package priority_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Rotate right so that bit k of the result is v[(k + amt) mod 8].
    function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] amt);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> amt;
        return dbl[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/priority_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface priority_arbiter_8_if;

    logic [7:0] req;
    logic       mode;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req, mode, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, mode, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/priority_arbiter_8_prio_enc.sv
// Combinational 8-input priority encoder: index of the highest set bit.
module prio_enc8_v
    import priority_arbiter_8_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/priority_arbiter_8.sv
// Fixed-priority / round-robin arbiter with non-preemptive grants, release on
// done or dropped request, and forced revocation after MAX_HOLD cycles.
module priority_arbiter_8
    import priority_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic                 clk,
    input logic                 rst,
    priority_arbiter_8_if.slave bus
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   rot_amt;
    logic [N_REQ-1:0]   rot_req;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               rel_now;
    logic               at_limit;

    // Round-robin: rotate so last-1 lands on bit 7, encode, rotate back (mod 8).
    assign rot_amt = (bus.mode == MODE_RR) ? last_q : '0;
    assign rot_req = rotr8(bus.req, rot_amt);
    assign win_idx = enc_idx + rot_amt;

    prio_enc8_v u_enc (
        .vec_i   (rot_req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign rel_now  = bus.done | ~bus.req[idx_q];
    assign at_limit = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                    gnt_d   = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                end
            end
            ST_GRANT: begin
                if (rel_now || at_limit) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    gnt_d     = '0;
                    idx_d     = '0;
                    last_d    = idx_q;
                    timeout_d = at_limit & ~rel_now;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == ST_GRANT);
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a grant-level behavioural model.
module tb_priority_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_arbiter_8_if bus ();

    priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: current owner (-1 = none), previous owner, visible grant cycles.
    int m_owner   = -1;
    int m_last    = 0;
    int m_held    = 0;
    bit m_timeout = 1'b0;

    function automatic int pick(input logic [7:0] r, input logic m, input int last);
        if (m) begin
            for (int j = 1; j <= 8; j++) begin
                int k;
                k = (last - j + 8) % 8;
                if (r[k]) return k;
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (r[k]) return k;
            end
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic m, input logic d, input logic rs);
        if (rs) begin
            m_owner = -1; m_last = 0; m_held = 0; m_timeout = 1'b0;
        end else if (m_owner < 0) begin
            m_timeout = 1'b0;
            m_owner   = pick(r, m, m_last);
            m_held    = (m_owner >= 0) ? 1 : 0;
        end else begin
            bit rel;
            bit lim;
            rel = d || !r[m_owner];
            lim = (m_held == MAX_HOLD);
            if (rel || lim) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_held    = 0;
                m_timeout = lim && !rel;
            end else begin
                m_held++;
                m_timeout = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [7:0] e_gnt;
        e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("model_gnt", bus.gnt, e_gnt);
        check("model_idx", {5'b0, bus.gnt_idx}, (m_owner < 0) ? 8'd0 : 8'(m_owner));
        check("model_valid", {7'b0, bus.gnt_valid}, (m_owner < 0) ? 8'd0 : 8'd1);
        check("model_timeout", {7'b0, bus.timeout}, {7'b0, m_timeout});
    endtask

    task automatic step(input logic [7:0] r, input logic m, input logic d, input logic rs);
        bus.req  = r;
        bus.mode = m;
        bus.done = d;
        rst      = rs;
        @(posedge clk);
        model_edge(r, m, d, rs);
        #1;
        check_model();
    endtask

    initial begin
        int got [9];
        int hi;
        bit cleared;
        logic [7:0] r;

        bus.req = '0; bus.mode = 1'b0; bus.done = 1'b0;

        // Reset state and fixed-priority pick.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        check("rst_gnt", bus.gnt, 8'h00);
        step(8'b0010_0110, 1'b0, 1'b0, 1'b0);
        check("fixed_gnt", bus.gnt, 8'b0010_0000);
        check("fixed_idx", {5'b0, bus.gnt_idx}, 8'd5);
        check("fixed_valid", {7'b0, bus.gnt_valid}, 8'd1);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Round-robin rotation with done every grant.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b0, 1'b0);
            got[i] = int'(bus.gnt_idx);
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            check("rr_gap", bus.gnt, 8'h00);
        end
        for (int i = 0; i < 9; i++) begin
            check("rr_seq", 8'(got[i]), (i == 8) ? 8'd7 : 8'(7 - i));
        end

        // Forced revocation after MAX_HOLD cycles, then re-grant.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0, 1'b0);
        hi = (bus.gnt != 8'h00) ? 1 : 0;
        cleared = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!cleared) begin
                step(8'h08, 1'b0, 1'b0, 1'b0);
                if (bus.gnt != 8'h00) hi++;
                else begin
                    cleared = 1'b1;
                    check("hold_timeout", {7'b0, bus.timeout}, 8'd1);
                end
            end
        end
        check("hold_cleared", {7'b0, cleared}, 8'd1);
        check("hold_cycles", 8'(hi), 8'(MAX_HOLD));
        step(8'h08, 1'b0, 1'b0, 1'b0);
        check("regrant_gnt", bus.gnt, 8'h08);
        check("regrant_timeout", {7'b0, bus.timeout}, 8'd0);

        // Dropped request: no preemption, clean release, then next winner.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h10, 1'b0, 1'b0, 1'b0);
        step(8'h90, 1'b0, 1'b0, 1'b0);
        check("nopreempt_idx", {5'b0, bus.gnt_idx}, 8'd4);
        step(8'h80, 1'b0, 1'b0, 1'b0);
        check("drop_gnt", bus.gnt, 8'h00);
        check("drop_timeout", {7'b0, bus.timeout}, 8'd0);
        step(8'h80, 1'b0, 1'b0, 1'b0);
        check("drop_next_idx", {5'b0, bus.gnt_idx}, 8'd7);

        // done coinciding with the counter limit: release without timeout.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step(8'h08, 1'b0, 1'b0, 1'b0);
        check("limit_still_held", bus.gnt, 8'h08);
        step(8'h08, 1'b0, 1'b1, 1'b0);
        check("limit_done_gnt", bus.gnt, 8'h00);
        check("limit_done_timeout", {7'b0, bus.timeout}, 8'd0);

        // Reset mid-grant clears last back to 0.
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        check("rr_after3_idx", {5'b0, bus.gnt_idx}, 8'd2);
        step(8'hFF, 1'b1, 1'b0, 1'b1);
        check("midrst_gnt", bus.gnt, 8'h00);
        check("midrst_timeout", {7'b0, bus.timeout}, 8'd0);
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        check("midrst_next_idx", {5'b0, bus.gnt_idx}, 8'd7);

        // Random traffic with sticky requests so holds and timeouts occur.
        r = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
